// File: rtl/imem_loader.sv
// Serial program loader: receives a framed UART byte stream and writes big-endian
// 32-bit words into instruction memory while holding the CPU in reset.
module imem_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              RXD,
  output logic              IMWE,
  output logic [ADDR_W-1:0] IMWAddr,
  output logic [31:0]       IMWData,
  output logic              CPU_HOLD,
  output logic              DONE,
  output logic              ERR
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {WAIT_HDR, CNT_HI, CNT_LO, DATA, LOADED, FAIL} ld_state_t;

  // Receiver state
  rx_state_t        r_rx_state;
  logic             r_rxd_s1, r_rxd_s2, r_rxd_d;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  // Loader state
  ld_state_t        r_ld_state;
  logic [7:0]       r_cnt_hi;
  logic [15:0]      r_n;
  logic [ADDR_W:0]  r_idx;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_asm;
  logic             r_imwe, r_hold, r_done, r_err;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]      r_data;

  logic        w_fall, w_stop_tick, w_rx_valid, w_rx_ferr, w_hdr, w_last, w_bad_n;
  logic [7:0]  w_rx_byte;
  logic [15:0] w_n;

  assign w_fall      = r_rxd_d & ~r_rxd_s2;
  assign w_stop_tick = (r_rx_state == RX_STOP) && (r_clk_cnt == BIT_LAST);
  // Strobes are combinational in the stop-bit sample cycle; the loader registers them.
  assign w_rx_valid  = w_stop_tick & r_rxd_s2;
  assign w_rx_ferr   = w_stop_tick & ~r_rxd_s2;
  assign w_rx_byte   = r_shift;
  assign w_hdr       = w_rx_valid && (w_rx_byte == 8'hA5);
  assign w_n         = {r_cnt_hi, w_rx_byte};
  assign w_bad_n     = (w_n == 16'd0) || (17'(w_n) > MAX_WORDS);
  assign w_last      = (17'(r_idx) == (17'(r_n) - 17'd1));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_rxd_s1   <= 1'b1;
      r_rxd_s2   <= 1'b1;
      r_rxd_d    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_rxd_s1 <= RXD;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s2;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          if (w_fall) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (r_clk_cnt == HALF_LAST) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_rx_state <= r_rxd_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == BIT_LAST) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rxd_s2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (w_stop_tick) begin
            r_clk_cnt  <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_ld_state <= WAIT_HDR;
      r_cnt_hi   <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_imwe     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_hold     <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_imwe <= 1'b0;
      case (r_ld_state)
        WAIT_HDR, LOADED, FAIL: begin
          // LOADED is entered alongside the final write, so release lands one cycle later.
          if (r_ld_state == LOADED) begin
            r_hold <= 1'b0;
            r_done <= 1'b1;
          end
          if (w_hdr) begin
            r_ld_state <= CNT_HI;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
          end
        end
        CNT_HI: begin
          if (w_rx_ferr) begin
            r_ld_state <= FAIL;
            r_err      <= 1'b1;
          end else if (w_rx_valid) begin
            r_cnt_hi   <= w_rx_byte;
            r_ld_state <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (w_rx_ferr || (w_rx_valid && w_bad_n)) begin
            r_ld_state <= FAIL;
            r_err      <= 1'b1;
          end else if (w_rx_valid) begin
            r_n        <= w_n;
            r_idx      <= '0;
            r_byte_cnt <= '0;
            r_ld_state <= DATA;
          end
        end
        DATA: begin
          if (w_rx_ferr) begin
            r_ld_state <= FAIL;
            r_err      <= 1'b1;
          end else if (w_rx_valid) begin
            r_asm <= {r_asm[15:0], w_rx_byte};
            if (r_byte_cnt == 2'd3) begin
              r_imwe     <= 1'b1;
              r_addr     <= r_idx[ADDR_W-1:0];
              r_data     <= {r_asm, w_rx_byte};
              r_idx      <= r_idx + 1'b1;
              r_byte_cnt <= '0;
              if (w_last) r_ld_state <= LOADED;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end
        default: r_ld_state <= WAIT_HDR;
      endcase
    end
  end

  assign IMWE     = r_imwe;
  assign IMWAddr  = r_addr;
  assign IMWData  = r_data;
  assign CPU_HOLD = r_hold;
  assign DONE     = r_done;
  assign ERR      = r_err;

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial program loader for the single-cycle MIPS core. It receives a framed byte stream on a UART line (8N1) and assembles big-endian 32-bit words. Each word is written into instruction memory through a dedicated write port, while the CPU is held in reset. When the last word is stored it releases the CPU; on an error it keeps the CPU held.

## Interface
Parameters:
- CLKS_PER_BIT, 434, CLK cycles per UART bit (50 MHz / 115200); minimum 4
- ADDR_W, 10, instruction-memory word-address width (1024 words)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-low (RST=0 resets on next CLK edge)
- RXD  in  1  UART receive line, idle high, asynchronous to CLK
- IMWE  out  1  instruction-memory write strobe, one cycle per word
- IMWAddr  out  ADDR_W  word address for IMWE
- IMWData  out  32  word data for IMWE
- CPU_HOLD  out  1  1 = hold CPU (drive core reset); 0 = CPU runs
- DONE  out  1  1 = complete image loaded, CPU released
- ERR  out  1  1 = load aborted (framing error or bad count)

## Operation
- Reset values: IMWE=0, IMWAddr=0, IMWData=0, CPU_HOLD=1, DONE=0, ERR=0. Receiver goes to RX_IDLE and loader goes to WAIT_HDR.
- RXD synchronizer: 2-flop synchronizer, reset to 1. Falling-edge detection runs on the synchronized value.
- Receiver FSM:
  - RX_IDLE: on a 1→0 transition go to RX_START.
  - RX_START: count CLKS_PER_BIT/2 cycles (integer division), then sample. If the sample is 1, it is a glitch: return to RX_IDLE. Otherwise go to RX_DATA.
  - RX_DATA: 8 samples, each CLKS_PER_BIT cycles apart, LSB first.
  - RX_STOP: sample after CLKS_PER_BIT cycles. If 1, pulse rx_valid for 1 cycle with rx_byte. If 0, pulse rx_ferr for 1 cycle. Return to RX_IDLE in both cases.
- Frame format: 0xA5 header, then COUNT_HI, then COUNT_LO (N = 16-bit word count, big-endian), then 4·N data bytes, MSB first per word.
- Loader FSM:
  - WAIT_HDR: bytes other than 0xA5 are ignored. 0xA5 → CNT_HI, which sets CPU_HOLD=1 and clears DONE and ERR.
  - CNT_HI: next byte → CNT_HI register → CNT_LO.
  - CNT_LO: next byte completes N. If N==0 or N>2^ADDR_W, go to FAIL. Otherwise clear the word index and byte counter, then go to DATA.
  - DATA: shift each byte into a 32-bit assembly register. On the 4th byte, write the word at address = index, then increment the index and clear the byte counter.
    - After the write with index==N−1 → LOADED.
  - LOADED: CPU_HOLD=0, DONE=1. Behaves as WAIT_HDR, so 0xA5 starts a reload and re-holds the CPU.
  - FAIL: ERR=1, CPU_HOLD=1, DONE=0. Behaves as WAIT_HDR for the restart.
- rx_ferr in CNT_HI, CNT_LO or DATA → FAIL. The partial word is discarded and words already written stay in memory. rx_ferr in WAIT_HDR, LOADED or FAIL is ignored.
- Count arithmetic: the index is ADDR_W+1 bits wide. The N>2^ADDR_W check uses the full 16-bit value, and the last-word compare is index==N−1.

## Timing
- Start-bit validation occurs CLKS_PER_BIT/2 cycles after the synchronized edge. The synchronizer adds 2 cycles of latency.
- rx_valid and rx_ferr are asserted exactly 1 cycle, during the stop-bit sample cycle.
- IMWE is registered: high the cycle after rx_valid of the 4th byte, for exactly 1 cycle. IMWAddr and IMWData are valid in the same cycle and hold their values until the next write.
- The last word: DONE rises and CPU_HOLD falls in the cycle after its IMWE, so the CPU never runs while a write is pending.
- Header during LOADED or FAIL: CPU_HOLD=1 and DONE=0 (or ERR=0) the cycle after its rx_valid.
- ERR rises the cycle after the offending rx_valid or rx_ferr.
- RST low mid-frame: all state is abandoned next edge and outputs return to reset values. No IMWE is issued for a partial word.
- The receiver is back to RX_IDLE by mid-stop-bit, so back-to-back bytes with no idle gap are accepted.

## Test plan
- Reset, then send 0xA5 00 02 12 34 56 78 DE AD BE EF:
  - IMWE twice: (0, 0x12345678), then (1, 0xDEADBEEF).
  - DONE=1 and CPU_HOLD=0 one cycle after the second IMWE.
- Send 0x00 0x5A, then 0xA5 00 01 00 00 00 01: leading bytes ignored; one write (0, 0x00000001); DONE=1.
- Count checks, each expecting ERR=1, CPU_HOLD=1 and no IMWE:
  - 0xA5 00 00.
  - 0xA5 04 01 (N=1025).
  - After either, a valid frame clears ERR and loads normally.
- Send 0xA5 00 02 AA BB CC DD, then a byte with stop bit 0:
  - Word 0 written.
  - ERR=1 and no second IMWE.
- RXD low pulse shorter than CLKS_PER_BIT/2: no rx_valid, state unchanged. Separately, drop RST low for 1 cycle after 2 data bytes: all outputs return to reset values and no write occurs.
- After DONE, send 0xA5 00 01 CA FE BA BE: CPU_HOLD=1 the cycle after the header; write (0, 0xCAFEBABE); CPU released again.
